// File: rtl/radio_spi_master.sv
// SPI write master for the MAX2829 radio (18-bit words) and AD9777 DAC (16-bit words).
// Define RADIO_SPI_QUEUE_EN to place a 2-entry command FIFO in front of the shifter.
module radio_spi_master #(
   parameter int CLK_DIV    = 4,
   parameter int CS_GAP     = 4,
   parameter int RADIO_BITS = 18,
   parameter int DAC_BITS   = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_target,
   input  logic [0:23] cmd_data,
   output logic        busy,
   output logic        done,
   output logic        controller_spi_clk,
   output logic        controller_spi_data,
   output logic        controller_radio_cs,
   output logic        controller_dac_cs
);
   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

   localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [4:0]  bits_left;
   logic [23:0] shift;
   logic        start;
   logic        src_target;
   logic [23:0] src_word;
   logic        phase_end;
   logic        next_active;
   logic        busy_nxt;

   assign phase_end   = (cnt == 8'd0);
   assign next_active = start || (state != IDLE && !(state == GAP && phase_end));

`ifdef RADIO_SPI_QUEUE_EN
   logic [24:0] fifo_mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  fifo_cnt;
   logic [1:0]  fifo_cnt_nxt;
   logic        push;

   assign cmd_ready    = (fifo_cnt != 2'd2);
   assign push         = cmd_valid && cmd_ready;
   // The shifter takes the next entry on the last GAP cycle, or straight away when idle.
   assign start        = (fifo_cnt != 2'd0) && (state == IDLE || (state == GAP && phase_end));
   assign {src_target, src_word} = fifo_mem[rd_ptr];
   assign fifo_cnt_nxt = fifo_cnt + {1'b0, push} - {1'b0, start};
   assign busy_nxt     = next_active || (fifo_cnt_nxt != 2'd0);

   // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {cmd_target, cmd_data};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (push)  wr_ptr <= ~wr_ptr;
         if (start) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt_nxt;
      end
   end
`else
   assign cmd_ready  = (state == IDLE);
   assign start      = cmd_valid && (state == IDLE);
   assign src_target = cmd_target;
   assign src_word   = cmd_data;
   assign busy_nxt   = next_active;
`endif

   // NOTE: every register here uses non-blocking assignment so each branch reads pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state               <= IDLE;
         cnt                 <= 8'd0;
         bits_left           <= 5'd0;
         shift               <= 24'd0;
         busy                <= 1'b0;
         done                <= 1'b0;
         controller_spi_clk  <= 1'b0;
         controller_spi_data <= 1'b0;
         controller_radio_cs <= 1'b1;
         controller_dac_cs   <= 1'b1;
      end else begin
         done <= 1'b0;
         busy <= busy_nxt;
         if (start) begin
            state               <= SETUP;
            cnt                 <= DIV_LOAD;
            controller_radio_cs <= src_target;
            controller_dac_cs   <= ~src_target;
            if (src_target) begin
               shift               <= src_word << (24 - DAC_BITS);
               controller_spi_data <= src_word[DAC_BITS-1];
               bits_left           <= 5'(DAC_BITS);
            end else begin
               shift               <= src_word << (24 - RADIO_BITS);
               controller_spi_data <= src_word[RADIO_BITS-1];
               bits_left           <= 5'(RADIO_BITS);
            end
         end else begin
            if (!phase_end) cnt <= cnt - 8'd1;
            unique case (state)
               IDLE: ;
               SETUP: if (phase_end) begin
                  state              <= HIGH;
                  controller_spi_clk <= 1'b1;
                  cnt                <= DIV_LOAD;
               end
               HIGH: if (phase_end) begin
                  state              <= LOW;
                  controller_spi_clk <= 1'b0;
                  cnt                <= DIV_LOAD;
                  bits_left          <= bits_left - 5'd1;
                  // After the last bit the data line holds while LOW serves as cs hold time.
                  if (bits_left != 5'd1) begin
                     shift               <= shift << 1;
                     controller_spi_data <= shift[22];
                  end
               end
               LOW: if (phase_end) begin
                  if (bits_left != 5'd0) begin
                     state              <= HIGH;
                     controller_spi_clk <= 1'b1;
                     cnt                <= DIV_LOAD;
                  end else begin
                     state               <= GAP;
                     controller_radio_cs <= 1'b1;
                     controller_dac_cs   <= 1'b1;
                     controller_spi_data <= 1'b0;
                     done                <= 1'b1;
                     cnt                 <= GAP_LOAD;
                  end
               end
               GAP: if (phase_end) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_radio_spi_master.sv
// Bench for radio_spi_master: a default instance and a CLK_DIV=1 instance, checked by a
// scoreboard of expected words against a pin-level decoder of the SPI bus.
module tb_radio_spi_master;
   localparam int CS_GAP     = 4;
   localparam int RADIO_BITS = 18;
   localparam int DAC_BITS   = 16;

   typedef struct {
      bit        tgt;
      int        n;
      bit [23:0] val;
   } word_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        target = 1'b0;
   logic [23:0] data = 24'd0;
   logic        valid [2];
   logic        ready [2];
   logic        busy  [2];
   logic        done  [2];
   logic        sclk  [2];
   logic        sdat  [2];
   logic        rcs   [2];
   logic        dcs   [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   word_t exp_q0[$];
   word_t exp_q1[$];
   int    gap_q0[$];
   word_t tr_w;
   word_t e;
   bit    got_exp;

   // Decoder state, one slot per instance
   bit        in_word  [2];
   bit        tgt      [2];
   bit        prev_clk [2];
   bit        prev_dat [2];
   bit        have_prev[2];
   bit        gap_phase[2];
   int        len      [2];
   int        nb       [2];
   int        tog      [2];
   int        hi_cnt   [2];
   int        gap_cnt  [2];
   int        last_len [2];
   int        done_cnt [2];
   int        words    [2];
   int        acc_cnt  [2];
   bit [23:0] bits     [2];
   bit [23:0] last_bits[2];

   radio_spi_master u_dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .cmd_valid           (valid[0]),
      .cmd_ready           (ready[0]),
      .cmd_target          (target),
      .cmd_data            (data),
      .busy                (busy[0]),
      .done                (done[0]),
      .controller_spi_clk  (sclk[0]),
      .controller_spi_data (sdat[0]),
      .controller_radio_cs (rcs[0]),
      .controller_dac_cs   (dcs[0])
   );

   radio_spi_master #(.CLK_DIV(1)) u_fast (
      .clk                 (clk),
      .reset_n             (reset_n),
      .cmd_valid           (valid[1]),
      .cmd_ready           (ready[1]),
      .cmd_target          (target),
      .cmd_data            (data),
      .busy                (busy[1]),
      .done                (done[1]),
      .controller_spi_clk  (sclk[1]),
      .controller_spi_data (sdat[1]),
      .controller_radio_cs (rcs[1]),
      .controller_dac_cs   (dcs[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic int div_of(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   // Reference model: which bits of the command the slave should receive.
   function automatic word_t model(input logic t, input logic [23:0] d);
      word_t w;
      w.tgt = t;
      w.n   = t ? DAC_BITS : RADIO_BITS;
      w.val = d & ((24'd1 << w.n) - 24'd1);
      return w;
   endfunction

   // Stimulus side of the scoreboard: an accept happens at the posedge after this sample.
   always @(negedge clk) begin
      if (reset_n) begin
         for (int k = 0; k < 2; k++) begin
            if (valid[k] && ready[k]) begin
               acc_cnt[k]++;
               tr_w = model(target, data);
               if (k == 0) exp_q0.push_back(tr_w);
               else        exp_q1.push_back(tr_w);
            end
         end
      end
   end

   // Monitor: rebuilds each word from the SPI pins and compares with the scoreboard.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (done[k]) done_cnt[k]++;
         if (!reset_n) begin
            if (in_word[k]) check("no done on aborted word", done[k], 1'b0);
            in_word[k]   = 1'b0;
            have_prev[k] = 1'b0;
            gap_phase[k] = 1'b0;
         end else if (in_word[k]) begin
            if (rcs[k] && dcs[k]) begin
               in_word[k]   = 1'b0;
               words[k]++;
               last_len[k]  = len[k];
               last_bits[k] = bits[k];
               check("done pulse at cs rise", done[k], 1'b1);
               check("busy at cs rise", busy[k], 1'b1);
               check("data idles 0 after word", sdat[k], 1'b0);
               got_exp = 1'b0;
               if (k == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); got_exp = 1'b1; end
               if (k == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); got_exp = 1'b1; end
               check("scoreboard entry present", got_exp, 1'b1);
               if (got_exp) begin
                  check("word target", tgt[k], e.tgt);
                  check("rising edge count", nb[k], e.n);
                  check("word bits", bits[k], e.val);
                  check("cs low cycles", len[k], div_of(k) * (1 + 2 * e.n));
                  check("spi_clk toggles", tog[k], 2 * e.n);
               end
               have_prev[k] = 1'b1;
               hi_cnt[k]    = 1;
               gap_phase[k] = !ready[k];
               gap_cnt[k]   = 1;
            end else begin
               len[k]++;
               check("other cs stays high", tgt[k] ? rcs[k] : dcs[k], 1'b1);
               check("no done mid-word", done[k], 1'b0);
               if (sclk[k] != prev_clk[k]) tog[k]++;
               if (sclk[k] && !prev_clk[k]) begin
                  check("data stable across rising edge", sdat[k], prev_dat[k]);
                  bits[k] = {bits[k][22:0], sdat[k]};
                  nb[k]++;
               end
            end
         end else begin
`ifndef RADIO_SPI_QUEUE_EN
            if (gap_phase[k]) begin
               if (ready[k]) begin
                  gap_phase[k] = 1'b0;
                  check("cmd_ready returns after gap", gap_cnt[k], CS_GAP);
               end else if (gap_cnt[k] > 1000) begin
                  gap_phase[k] = 1'b0;
                  check("cmd_ready returns within budget", 0, 1);
               end else begin
                  gap_cnt[k]++;
               end
            end
`endif
            if (!rcs[k] || !dcs[k]) begin
               check("only one cs low", rcs[k] | dcs[k], 1'b1);
               if (have_prev[k]) begin
                  check("cs high gap at least CS_GAP", hi_cnt[k] >= CS_GAP, 1'b1);
                  if (k == 0) gap_q0.push_back(hi_cnt[k]);
               end
               check("spi_clk low at word start", sclk[k], 1'b0);
               in_word[k] = 1'b1;
               tgt[k]     = !dcs[k];
               len[k]     = 1;
               nb[k]      = 0;
               tog[k]     = 0;
               bits[k]    = 24'd0;
            end else begin
               hi_cnt[k]++;
            end
         end
         prev_clk[k] = sclk[k];
         prev_dat[k] = sdat[k];
      end
   end

   task automatic send(input int k, input logic t, input logic [23:0] d);
      int n;
      @(posedge clk); #1;
      target   = t;
      data     = d;
      valid[k] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!ready[k] && n < 2000) begin @(negedge clk); n++; end
      check("accept within budget", n < 2000, 1'b1);
      @(posedge clk); #1;
      valid[k] = 1'b0;
   endtask

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      repeat (2) @(negedge clk);
      while ((busy[k] || in_word[k]) && n < 5000) begin @(negedge clk); n++; end
      check("idle within budget", n < 5000, 1'b1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int a0;
      int dc;
      logic [23:0] d;
      logic [23:0] bp_last;
      valid[0] = 1'b0;
      valid[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check("reset spi_clk", sclk[k], 1'b0);
         check("reset spi_data", sdat[k], 1'b0);
         check("reset radio_cs", rcs[k], 1'b1);
         check("reset dac_cs", dcs[k], 1'b1);
         check("reset done", done[k], 1'b0);
         check("reset busy", busy[k], 1'b0);
         check("reset cmd_ready", ready[k], 1'b1);
      end
      @(negedge clk);
      reset_n = 1'b1;

      // Directed radio and DAC words
      send(0, 1'b0, 24'h031234);
      wait_idle(0);
      check("radio cs low 148", last_len[0], 148);
      check("radio bits 0x31234", last_bits[0], 24'h031234);
      send(0, 1'b1, 24'h00A55A);
      wait_idle(0);
      check("dac cs low 132", last_len[0], 132);
      check("dac bits 0xA55A", last_bits[0], 24'h00A55A);

      // Random words, both targets
      for (int i = 0; i < 8; i++) begin
         send(0, 1'($urandom_range(0, 1)), 24'($urandom));
         if (i % 2 == 1) wait_idle(0);
      end
      wait_idle(0);

`ifndef RADIO_SPI_QUEUE_EN
      // Back-pressure: valid held high while the input data keeps changing
      a0 = acc_cnt[0];
      @(posedge clk); #1;
      target   = 1'b0;
      data     = 24'($urandom);
      valid[0] = 1'b1;
      repeat (10) begin
         repeat (10) @(posedge clk);
         #1;
         target = 1'($urandom_range(0, 1));
         data   = 24'($urandom);
      end
      check("single accept while busy", acc_cnt[0] - a0, 1);
      bp_last = 24'($urandom);
      target  = 1'b1;
      data    = bp_last;
      n = 0;
      while (acc_cnt[0] - a0 < 2 && n < 2000) begin @(negedge clk); n++; end
      check("second accept within budget", n < 2000, 1'b1);
      @(posedge clk); #1;
      valid[0] = 1'b0;
      wait_idle(0);
      check("back-pressure word uses data at accept", last_bits[0], bp_last & 24'h00FFFF);
`endif

      // Reset in the middle of a radio word
      send(0, 1'b0, 24'h02ABCD);
      n = 0;
      while (!(in_word[0] && nb[0] >= 7) && n < 2000) begin @(negedge clk); n++; end
      check("reached bit 7", n < 2000, 1'b1);
      dc = done_cnt[0];
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      check("abort radio_cs high", rcs[0], 1'b1);
      check("abort dac_cs high", dcs[0], 1'b1);
      check("abort spi_clk low", sclk[0], 1'b0);
      check("abort spi_data low", sdat[0], 1'b0);
      check("abort busy low", busy[0], 1'b0);
      exp_q0.delete();
      repeat (3) @(negedge clk);
      check("no done pulse on abort", done_cnt[0], dc);
      d        = 24'($urandom);
      target   = 1'b0;
      data     = d;
      valid[0] = 1'b1;
      @(posedge clk); #2;
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("accept on first edge after release", busy[0], 1'b1);
      valid[0] = 1'b0;
      wait_idle(0);
      check("fresh word after reset", last_bits[0], d & 24'h03FFFF);

      // CLK_DIV=1 corner
      send(1, 1'b0, 24'h031234);
      wait_idle(1);
      check("fast radio cs low 37", last_len[1], 37);
      check("fast radio bits", last_bits[1], 24'h031234);
      for (int i = 0; i < 4; i++) begin
         send(1, 1'($urandom_range(0, 1)), 24'($urandom));
         wait_idle(1);
      end

`ifdef RADIO_SPI_QUEUE_EN
      begin
         int acc_at [3];
         int busy_low;
         dc = done_cnt[0];
         gap_q0.delete();
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) begin
            target   = (i == 1);
            data     = 24'($urandom);
            valid[0] = 1'b1;
            n = 0;
            @(negedge clk);
            while (!ready[0] && n < 2000) begin @(negedge clk); n++; end
            acc_at[i] = cyc;
            @(posedge clk); #1;
         end
         valid[0] = 1'b0;
         check("second queued accept is immediate", acc_at[1] - acc_at[0], 1);
         check("third accept after first pop", acc_at[2] - acc_at[1], 1);
         busy_low = 0;
         n = 0;
         while (done_cnt[0] - dc < 3 && n < 3000) begin
            @(negedge clk);
            if (!busy[0]) busy_low++;
            n++;
         end
         check("three done pulses", done_cnt[0] - dc, 3);
         check("busy high throughout queue", busy_low, 0);
         wait_idle(0);
         check("two gaps recorded", gap_q0.size() >= 2, 1'b1);
         if (gap_q0.size() >= 2) begin
            check("gap before word 2", gap_q0[gap_q0.size() - 2], CS_GAP);
            check("gap before word 3", gap_q0[gap_q0.size() - 1], CS_GAP);
         end
      end
`endif

      repeat (5) @(negedge clk);
      check("scoreboard drained 0", exp_q0.size(), 0);
      check("scoreboard drained 1", exp_q1.size(), 0);
      check("done count matches words 0", done_cnt[0], words[0]);
      check("done count matches words 1", done_cnt[1], words[1]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
